// File: rtl/sd_spi_cmd_master.sv
// SD card SPI-mode command engine: sends one 48-bit command frame and
// polls for the R1 response byte, or times out.
//
// state  | meaning
// IDLE   | waiting for start, SPI pins idle
// SEND   | shifting the 48-bit command frame out on mosi
// RESP   | clocking response bytes in until bit7=0 or NCR_MAX bytes
// FINISH | one-cycle done/timeout pulse, then release the bus
module sd_spi_cmd_master #(
  parameter int CLK_DIV      = 4,
  parameter int NCR_MAX      = 8,
  parameter int COMMAND_SIZE = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  resp,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam int FRAME_W = COMMAND_SIZE * 8;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W  = (NCR_MAX > 1) ? $clog2(NCR_MAX + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_TC     = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(NCR_MAX - 1);
  localparam logic [5:0]        FRAME_LAST = 6'(FRAME_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]         state;
  logic [FRAME_W-1:0] frame;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_cnt;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [7:0]         rx_sh;

  logic [FRAME_W-1:0] frame_in;
  logic [7:0]         rx_next;
  logic               running;
  logic               tick;
  logic               sclk_rise;
  logic               sclk_fall;

  assign frame_in  = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
  assign rx_next   = {rx_sh[6:0], miso};
  assign running   = (state == S_SEND) || (state == S_RESP);
  assign tick      = running && (div_cnt == DIV_TC);
  assign sclk_rise = tick && !sclk;
  assign sclk_fall = tick && sclk;

  // Command/response sequencer, sclk divider and SPI pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      frame    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sh    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b1;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      resp     <= 8'hFF;
    end else begin
      if (running) begin
        if (tick) begin
          div_cnt <= '0;
          sclk    <= ~sclk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          timeout <= 1'b0;
          if (start) begin
            frame    <= frame_in;
            mosi     <= frame_in[FRAME_W-1];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            sclk     <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (sclk_fall) begin
            if (bit_cnt == FRAME_LAST) begin
              mosi     <= 1'b1;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              state    <= S_RESP;
            end else begin
              // frame[MSB] is already on the wire, so the next bit is one below it
              mosi    <= frame[FRAME_W-2];
              frame   <= {frame[FRAME_W-2:0], 1'b1};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_RESP: begin
          if (sclk_rise) begin
            rx_sh <= rx_next;
            if (bit_cnt == 6'd7) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 1'b1;
              if (!rx_next[7]) begin
                resp  <= rx_next;
                done  <= 1'b1;
                state <= S_FINISH;
              end else if (byte_cnt == BYTE_LAST) begin
                resp    <= 8'hFF;
                timeout <= 1'b1;
                state   <= S_FINISH;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          done     <= 1'b0;
          timeout  <= 1'b0;
          sclk     <= 1'b0;
          mosi     <= 1'b1;
          cs_n     <= 1'b1;
          busy     <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
